// File: rtl/inst_loader.sv
// Boot loader for the mips_pipeline instruction memory: takes a framed byte stream,
// writes big-endian words from address 0, verifies an XOR checksum and gates cpu_rst.
//
// state   | meaning
// HDR_HI  | waiting for word-count high byte
// HDR_LO  | waiting for word-count low byte, range-check count
// DATA    | assembling 4-byte words, one write per completed word
// CKSUM   | waiting for checksum byte, compare to running XOR
// DONE    | load good, pipeline released, stream ignored
// ERR     | load aborted, pipeline held in reset, stream ignored
module inst_loader #(
   parameter int ADDR_W    = 10,
   parameter int MEM_DEPTH = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic              reload,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_data,
   output logic              mem_wren,
   output logic              cpu_rst,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_HDR_HI,
      S_HDR_LO,
      S_DATA,
      S_CKSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0] DEPTH_L = 17'(MEM_DEPTH);

   state_t            state_q, state_d;
   logic [15:0]       count_q, count_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [ADDR_W:0]   wcnt_q, wcnt_d;
   logic [7:0]        xor_q, xor_d;
   logic [23:0]       asm_q, asm_d;
   logic              wren_q, wren_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;

   logic [ADDR_W:0]   wcnt_inc;
   logic [15:0]       count_full;

   // word counter is one bit wider than the address so it can reach MEM_DEPTH
   assign wcnt_inc   = wcnt_q + 1'b1;
   assign count_full = {count_q[15:8], byte_in};

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      bcnt_d     = bcnt_q;
      wcnt_d     = wcnt_q;
      xor_d      = xor_q;
      asm_d      = asm_q;
      wren_d     = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      byte_ready = 1'b0;
      case (state_q)
         S_HDR_HI: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               count_d[15:8] = byte_in;
               xor_d         = xor_q ^ byte_in;
               state_d       = S_HDR_LO;
            end
         end
         S_HDR_LO: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               count_d[7:0] = byte_in;
               xor_d        = xor_q ^ byte_in;
               if ({1'b0, count_full} > DEPTH_L)
                  state_d = S_ERR;
               else if (count_full == 16'd0)
                  state_d = S_CKSUM;
               else
                  state_d = S_DATA;
            end
         end
         S_DATA: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               xor_d  = xor_q ^ byte_in;
               bcnt_d = bcnt_q + 2'd1;
               asm_d  = {asm_q[15:0], byte_in};
               if (bcnt_q == 2'd3) begin
                  wren_d = 1'b1;
                  data_d = {asm_q, byte_in};
                  addr_d = wcnt_q[ADDR_W-1:0];
                  wcnt_d = wcnt_inc;
                  // last word: the write lands while already in CKSUM
                  if (16'(wcnt_inc) == count_q)
                     state_d = S_CKSUM;
               end
            end
         end
         S_CKSUM: begin
            byte_ready = 1'b1;
            if (byte_valid)
               state_d = (byte_in == xor_q) ? S_DONE : S_ERR;
         end
         S_DONE, S_ERR: begin
            if (reload) begin
               state_d = S_HDR_HI;
               count_d = '0;
               bcnt_d  = '0;
               wcnt_d  = '0;
               xor_d   = '0;
               asm_d   = '0;
            end
         end
         default: state_d = S_HDR_HI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_HDR_HI;
         count_q <= '0;
         bcnt_q  <= '0;
         wcnt_q  <= '0;
         xor_q   <= '0;
         asm_q   <= '0;
         wren_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         bcnt_q  <= bcnt_d;
         wcnt_q  <= wcnt_d;
         xor_q   <= xor_d;
         asm_q   <= asm_d;
         wren_q  <= wren_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign mem_wren    = wren_q;
   assign mem_address = addr_q;
   assign mem_data    = data_q;
   assign done        = (state_q == S_DONE);
   assign error       = (state_q == S_ERR);
   assign cpu_rst     = (state_q != S_DONE);

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: framed streams with hand-computed write logs,
// handshake outputs and cpu_rst/done/error results.
module tb_inst_loader;

   logic        clk;
   logic        rst;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        reload;
   logic [9:0]  mem_address;
   logic [31:0] mem_data;
   logic        mem_wren;
   logic        cpu_rst;
   logic        done;
   logic        error;

   int n_vec = 0;
   int n_err = 0;

   logic [9:0]  wr_addr [64];
   logic [31:0] wr_data [64];
   int          wr_cnt = 0;
   int          base;

   logic [7:0] stream [11] = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h26};

   inst_loader #(.ADDR_W(10), .MEM_DEPTH(1024)) dut (
      .clk         (clk),
      .rst         (rst),
      .byte_in     (byte_in),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .reload      (reload),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_wren    (mem_wren),
      .cpu_rst     (cpu_rst),
      .done        (done),
      .error       (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // write log sampled mid-cycle
   always @(negedge clk) begin
      if (mem_wren === 1'b1) begin
         if (wr_cnt < 64) begin
            wr_addr[wr_cnt] = mem_address;
            wr_data[wr_cnt] = mem_data;
         end
         wr_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run_two(input logic [7:0] last, input int gap);
      for (int i = 0; i < 10; i++) begin
         send(stream[i]);
         idle(gap);
      end
      send(last);
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(posedge clk); #1;
      reload = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(byte_ready), 32'd1);
      chk({tag, "_wren"},  32'(mem_wren),   32'd0);
      chk({tag, "_addr"},  32'(mem_address), 32'd0);
      chk({tag, "_data"},  mem_data,        32'd0);
      chk({tag, "_cpurst"}, 32'(cpu_rst),   32'd1);
      chk({tag, "_done"},  32'(done),       32'd0);
      chk({tag, "_err"},   32'(error),      32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      reload     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst = 1'b0;
      idle(1);

      // two-word load with write latency checks
      base = wr_cnt;
      for (int i = 0; i < 6; i++) send(stream[i]);
      chk("w0_wren", 32'(mem_wren), 32'd1);
      chk("w0_data", mem_data, 32'h2001_0005);
      chk("w0_addr", 32'(mem_address), 32'd0);
      for (int i = 6; i < 10; i++) send(stream[i]);
      chk("w1_wren", 32'(mem_wren), 32'd1);
      chk("w1_data", mem_data, 32'h0000_0000);
      chk("w1_addr", 32'(mem_address), 32'd1);
      send(8'h26);
      chk("t1_done",   32'(done),       32'd1);
      chk("t1_cpurst", 32'(cpu_rst),    32'd0);
      chk("t1_err",    32'(error),      32'd0);
      chk("t1_ready",  32'(byte_ready), 32'd0);
      chk("t1_wren",   32'(mem_wren),   32'd0);
      chk("t1_nwr",    32'(wr_cnt - base), 32'd2);
      send(8'h55);
      chk("t1_ign_done", 32'(done), 32'd1);
      chk("t1_ign_nwr",  32'(wr_cnt - base), 32'd2);
      pulse_reload();
      chk("rl1_cpurst", 32'(cpu_rst),    32'd1);
      chk("rl1_done",   32'(done),       32'd0);
      chk("rl1_ready",  32'(byte_ready), 32'd1);

      // empty program
      base = wr_cnt;
      send(8'h00); send(8'h00); send(8'h00);
      chk("t2_done",   32'(done),    32'd1);
      chk("t2_cpurst", 32'(cpu_rst), 32'd0);
      chk("t2_nwr",    32'(wr_cnt - base), 32'd0);
      pulse_reload();

      // bad checksum
      base = wr_cnt;
      run_two(8'h27, 0);
      chk("t3_nwr",    32'(wr_cnt - base), 32'd2);
      chk("t3_d0",     wr_data[base], 32'h2001_0005);
      chk("t3_a1",     32'(wr_addr[base + 1]), 32'd1);
      chk("t3_err",    32'(error),      32'd1);
      chk("t3_cpurst", 32'(cpu_rst),    32'd1);
      chk("t3_done",   32'(done),       32'd0);
      chk("t3_ready",  32'(byte_ready), 32'd0);
      pulse_reload();
      chk("rl3_err", 32'(error), 32'd0);

      // oversize count 0x0401
      base = wr_cnt;
      send(8'h04);
      chk("t4_mid_err", 32'(error), 32'd0);
      send(8'h01);
      chk("t4_err",   32'(error),      32'd1);
      chk("t4_ready", 32'(byte_ready), 32'd0);
      send(8'h00);
      send(8'h00);
      chk("t4_err2",  32'(error), 32'd1);
      chk("t4_nwr",   32'(wr_cnt - base), 32'd0);
      pulse_reload();

      // count of exactly 1024 is accepted
      send(8'h04);
      send(8'h00);
      chk("t4b_err",   32'(error),      32'd0);
      chk("t4b_ready", 32'(byte_ready), 32'd1);
      rst = 1'b1; idle(1); rst = 1'b0;

      // throttled two-word load
      base = wr_cnt;
      run_two(8'h26, 3);
      chk("t5_nwr",  32'(wr_cnt - base), 32'd2);
      chk("t5_d0",   wr_data[base], 32'h2001_0005);
      chk("t5_a0",   32'(wr_addr[base]), 32'd0);
      chk("t5_d1",   wr_data[base + 1], 32'h0000_0000);
      chk("t5_a1",   32'(wr_addr[base + 1]), 32'd1);
      chk("t5_done", 32'(done), 32'd1);
      pulse_reload();

      // rst on the cycle after the first word completes: word 0 stays written
      base = wr_cnt;
      for (int i = 0; i < 6; i++) send(stream[i]);
      rst = 1'b1; idle(1); rst = 1'b0;
      chk("t6a_nwr", 32'(wr_cnt - base), 32'd1);
      chk_reset_vals("t6a");

      // rst coincident with the 4th byte: pending write suppressed
      base = wr_cnt;
      for (int i = 0; i < 5; i++) send(stream[i]);
      rst        = 1'b1;
      byte_in    = stream[5];
      byte_valid = 1'b1;
      @(posedge clk); #1;
      rst        = 1'b0;
      byte_valid = 1'b0;
      chk_reset_vals("t6b");
      idle(2);
      chk("t6b_nwr", 32'(wr_cnt - base), 32'd0);

      base = wr_cnt;
      run_two(8'h26, 0);
      chk("t6c_done", 32'(done), 32'd1);
      chk("t6c_nwr",  32'(wr_cnt - base), 32'd2);
      chk("t6c_d0",   wr_data[base], 32'h2001_0005);
      pulse_reload();
      chk("rl6_cpurst", 32'(cpu_rst),    32'd1);
      chk("rl6_done",   32'(done),       32'd0);
      chk("rl6_ready",  32'(byte_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
